// File: rtl/shift_rot_ctrl.sv
// Start/busy/done sequencer for a shift/rotate register: loads a word, then applies
// a latched number of single-bit rotate or logical-shift steps, one per clock.
module shift_rot_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_l;
    logic             mode_l;
    logic [WIDTH-1:0] q_step;
    logic             fill;

    // The bit entering the vacated end: the wrapped-around bit for rotates, zero for shifts.
    always_comb begin
        fill   = 1'b0;
        q_step = q;
        if (dir_l) begin
            fill   = mode_l ? 1'b0 : q[WIDTH-1];
            q_step = {q[WIDTH-2:0], fill};
        end else begin
            fill   = mode_l ? 1'b0 : q[0];
            q_step = {fill, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            q      <= '0;
            cnt    <= '0;
            dir_l  <= 1'b0;
            mode_l <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q      <= a;
                        cnt    <= amount;
                        dir_l  <= dir;
                        mode_l <= mode;
                        if (amount != '0) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        q   <= q_step;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
